// File: rtl/srrc_pkg.sv
// rtl/srrc_pkg.sv - shared constants and state encoding for the folded SRRC scheduler
package srrc_pkg;

  function automatic int fold_of(input int ntaps);
    return (ntaps + 1) / 2;
  endfunction

  localparam int NTAPS    = 199;
  localparam int PIPE_LAT = 2;
  localparam int NFOLD    = fold_of(NTAPS);
  localparam int IDX_W    = $clog2(NTAPS);
  localparam int CIDX_W   = $clog2(NFOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

endpackage

// File: rtl/srrc_ctl_dly.sv
// rtl/srrc_ctl_dly.sv - LAT-stage delay of {issue_vld, first} aligning accumulator
// controls with the multiplier pipeline
module srrc_ctl_dly #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic vld_i,
  input  logic first_i,
  output logic acc_en_o,
  output logic acc_first_o
);

  logic [1:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {vld_i, first_i};
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign acc_en_o    = pipe_q[LAT-1][1];
  assign acc_first_o = pipe_q[LAT-1][0];

endmodule

// File: rtl/srrc_fold_mac_sched.sv
// rtl/srrc_fold_mac_sched.sv - tap-pair scheduler for a folded SRRC filter: issues
// symmetric index pairs, accumulator controls and the output strobe
module srrc_fold_mac_sched #(
  parameter int NTAPS    = srrc_pkg::NTAPS,
  parameter int PIPE_LAT = srrc_pkg::PIPE_LAT,
  parameter int IDX_W    = srrc_pkg::IDX_W,
  parameter int CIDX_W   = srrc_pkg::CIDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sam_clk_en,
  input  logic              clr_ovf,
  output logic              shift_en,
  output logic [CIDX_W-1:0] coef_idx,
  output logic [IDX_W-1:0]  x_lo_idx,
  output logic [IDX_W-1:0]  x_hi_idx,
  output logic              centre,
  output logic              issue_vld,
  output logic              acc_first,
  output logic              acc_en,
  output logic              out_stb,
  output logic              busy,
  output logic              ovf
);
  import srrc_pkg::*;

  localparam int NF = fold_of(NTAPS);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t            state_q, state_d;
  logic [CIDX_W-1:0] k_q, k_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic              ovf_q, ovf_d;
  logic              issue_q, issue_d;
  logic              centre_q, centre_d;
  logic [IDX_W-1:0]  xlo_q, xlo_d, xhi_q, xhi_d;
  logic              accept, last_tap, drn_done;

  always_comb begin
    accept   = sam_clk_en && !reset && (state_q == S_IDLE || state_q == S_DUMP);
    last_tap = (k_q == CIDX_W'(NF - 1));
    drn_done = (drn_q == DW'(PIPE_LAT - 1));
    state_d  = state_q;
    k_d      = k_q;
    drn_d    = drn_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        // k parks on the centre tap so the indices hold their last issued value
        if (last_tap) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          k_d = k_q + CIDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (drn_done) state_d = S_DUMP;
        else          drn_d   = drn_q + DW'(1);
      end
      S_DUMP: begin
        if (accept) begin
          state_d = S_RUN;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    issue_d  = (state_d == S_RUN);
    centre_d = issue_d && (k_d == CIDX_W'(NF - 1));
    xlo_d    = xlo_q;
    xhi_d    = xhi_q;
    if (issue_d) begin
      xlo_d = IDX_W'(k_d);
      xhi_d = IDX_W'(NTAPS - 1) - IDX_W'(k_d);
    end

    // a strobe landing mid-computation is dropped; set beats a simultaneous clear
    if (sam_clk_en && (state_q == S_RUN || state_q == S_DRAIN)) ovf_d = 1'b1;
    else if (clr_ovf)                                           ovf_d = 1'b0;
    else                                                        ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      drn_q    <= '0;
      ovf_q    <= 1'b0;
      issue_q  <= 1'b0;
      centre_q <= 1'b0;
      xlo_q    <= '0;
      xhi_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      drn_q    <= drn_d;
      ovf_q    <= ovf_d;
      issue_q  <= issue_d;
      centre_q <= centre_d;
      xlo_q    <= xlo_d;
      xhi_q    <= xhi_d;
    end
  end

  srrc_ctl_dly #(.LAT(PIPE_LAT)) u_ctl_dly (
    .clk         (clk),
    .reset       (reset),
    .vld_i       (issue_q),
    .first_i     (issue_q && (k_q == '0)),
    .acc_en_o    (acc_en),
    .acc_first_o (acc_first)
  );

  assign shift_en  = accept;
  assign coef_idx  = k_q;
  assign x_lo_idx  = xlo_q;
  assign x_hi_idx  = xhi_q;
  assign centre    = centre_q;
  assign issue_vld = issue_q;
  assign out_stb   = (state_q == S_DUMP);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_srrc_fold_mac_sched.sv
// tb/tb_srrc_fold_mac_sched.sv - scoreboard bench for the folded SRRC scheduler
module tb_srrc_fold_mac_sched;
  localparam int NT = 199;
  localparam int PL = 2;
  localparam int NF = (NT + 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, sam_clk_en = 1'b0, clr_ovf = 1'b0;
  logic       shift_en, centre, issue_vld, acc_first, acc_en, out_stb, busy, ovf;
  logic [6:0] coef_idx;
  logic [7:0] x_lo_idx, x_hi_idx;

  logic       reset_b = 1'b1, sam_b = 1'b0, clr_b = 1'b0;
  logic       shift_b, centre_b, issue_b, af_b, ae_b, os_b, busy_b, ovf_b;
  logic [0:0] coef_b;
  logic [1:0] lo_b, hi_b;

  srrc_fold_mac_sched dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .clr_ovf(clr_ovf),
    .shift_en(shift_en), .coef_idx(coef_idx), .x_lo_idx(x_lo_idx), .x_hi_idx(x_hi_idx),
    .centre(centre), .issue_vld(issue_vld), .acc_first(acc_first), .acc_en(acc_en),
    .out_stb(out_stb), .busy(busy), .ovf(ovf)
  );

  srrc_fold_mac_sched #(.NTAPS(3), .PIPE_LAT(1), .IDX_W(2), .CIDX_W(1)) dut_b (
    .clk(clk), .reset(reset_b), .sam_clk_en(sam_b), .clr_ovf(clr_b),
    .shift_en(shift_b), .coef_idx(coef_b), .x_lo_idx(lo_b), .x_hi_idx(hi_b),
    .centre(centre_b), .issue_vld(issue_b), .acc_first(af_b), .acc_en(ae_b),
    .out_stb(os_b), .busy(busy_b), .ovf(ovf_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; int k; bit f; } ev_t;
  ev_t iq[$];
  ev_t aq[$];
  int  oq[$];

  int m_dump = 0;
  int b_lo = 1, b_hi = 0;
  bit m_ovf = 1'b0, m_ovf_nx = 1'b0;

  task automatic push_sample(input int n);
    ev_t e;
    m_dump = n + NF + PL + 1;
    b_lo   = n + 1;
    b_hi   = n + NF + PL;
    for (int k = 0; k < NF; k++) begin
      e.cyc = n + 1 + k;       e.k = k; e.f = (k == NF - 1); iq.push_back(e);
      e.cyc = n + 1 + PL + k;  e.k = k; e.f = (k == 0);      aq.push_back(e);
    end
    oq.push_back(n + NF + PL + 1);
  endtask

  task automatic flush_after(input int n);
    while (iq.size() > 0 && iq[$].cyc > n) void'(iq.pop_back());
    while (aq.size() > 0 && aq[$].cyc > n) void'(aq.pop_back());
    while (oq.size() > 0 && oq[$] > n)     void'(oq.pop_back());
  endtask

  task automatic tick(input bit s, input bit c, input bit r);
    int n;
    bit acc_x, ovr;
    @(posedge clk); #1;
    sam_clk_en = s; clr_ovf = c; reset = r;
    n = cyc; acc_x = 1'b0; ovr = 1'b0;
    if (r) begin
      flush_after(n);
      m_dump = n + 1;
      if (b_hi > n) b_hi = n;
      m_ovf_nx = 1'b0;
    end else begin
      if (s && n >= m_dump) begin
        acc_x = 1'b1;
        push_sample(n);
      end else if (s) begin
        ovr = 1'b1;
      end
      m_ovf_nx = ovr ? 1'b1 : (c ? 1'b0 : m_ovf);
    end
    @(negedge clk);
    check("shift_en", 64'(shift_en), 64'(acc_x));
    check("busy", 64'(busy), 64'(n >= b_lo && n <= b_hi));
    check("ovf", 64'(ovf), 64'(m_ovf));
    m_ovf = m_ovf_nx;
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) tick(1'b0, 1'b0, 1'b0);
  endtask

  ev_t em;
  always @(negedge clk) begin
    if (issue_vld) begin
      if (iq.size() == 0) check("issue_extra", 64'd1, 64'd0);
      else begin
        em = iq.pop_front();
        check("issue", {32'(cyc), 8'(coef_idx), 8'(x_lo_idx), 8'(x_hi_idx), 7'd0, centre},
              {32'(em.cyc), 8'(em.k), 8'(em.k), 8'(NT - 1 - em.k), 7'd0, em.f});
      end
    end else if (centre) begin
      check("centre_no_issue", 64'd1, 64'd0);
    end
    if (acc_en || acc_first) begin
      if (aq.size() == 0) check("acc_extra", 64'd1, 64'd0);
      else begin
        em = aq.pop_front();
        check("acc", {32'(cyc), 7'd0, acc_en, 7'd0, acc_first},
              {32'(em.cyc), 7'd0, 1'b1, 7'd0, em.f});
      end
    end
    if (out_stb) begin
      if (oq.size() == 0) check("out_extra", 64'd1, 64'd0);
      else check("out_stb", 64'(cyc), 64'(oq.pop_front()));
    end
  end

  function automatic logic [12:0] expb(input bit sh, iv, co, input int lo, hi,
                                       input bit ct, af, ae, os, bz);
    return {sh, iv, co, 2'(lo), 2'(hi), ct, af, ae, os, bz, 1'b0};
  endfunction

  logic [12:0] eb;

  initial begin
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    reset_b = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check("rst_state", {shift_en, coef_idx, x_lo_idx, x_hi_idx, centre, issue_vld,
                        acc_first, acc_en, out_stb, busy, ovf}, 64'd0);

    // single sample
    tick(1'b1, 1'b0, 1'b0);
    idle(105);

    // ten samples at the minimum period, back to back through DUMP
    repeat (10) begin
      tick(1'b1, 1'b0, 1'b0);
      idle(102);
    end
    idle(105);

    // overrun mid-RUN, then clear
    tick(1'b1, 1'b0, 1'b0);
    idle(49);
    tick(1'b1, 1'b0, 1'b0);
    idle(60);
    tick(1'b0, 1'b1, 1'b0);
    idle(3);

    // reset abort at relative cycle 40, restart at 45
    tick(1'b1, 1'b0, 1'b0);
    idle(39);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("abort_zero", {shift_en, coef_idx, x_lo_idx, x_hi_idx, centre, issue_vld,
                         acc_first, acc_en, out_stb, busy, ovf}, 64'd0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    idle(110);

    // clear and overrun in the same cycle: set wins
    tick(1'b1, 1'b0, 1'b0);
    idle(10);
    tick(1'b1, 1'b1, 1'b0);
    idle(2);
    check("ovf_set_wins", 64'(ovf), 64'd1);
    idle(100);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);

    // small configuration: NTAPS=3, PIPE_LAT=1
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sam_b = (i == 0);
      @(negedge clk);
      case (i)
        0:       eb = expb(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        1:       eb = expb(0, 1, 0, 0, 2, 0, 0, 0, 0, 1);
        2:       eb = expb(0, 1, 1, 1, 1, 1, 1, 1, 0, 1);
        3:       eb = expb(0, 0, 1, 1, 1, 0, 0, 1, 0, 1);
        4:       eb = expb(0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
        default: eb = expb(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
      endcase
      check($sformatf("small_off%0d", i),
            64'({shift_b, issue_b, coef_b, lo_b, hi_b, centre_b, af_b, ae_b, os_b, busy_b, ovf_b}),
            64'(eb));
    end
    sam_b = 1'b0;

    check("issue_left", 64'(iq.size()), 64'd0);
    check("acc_left", 64'(aq.size()), 64'd0);
    check("out_left", 64'(oq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
